// File: rtl/opdecode_if.sv
// rtl/opdecode_if.sv - draw command bus between command source and opdecode
//
// Signals:
//   opcode    [95:0] packed draw command {shape[3:0], color[15:0], opdata[75:0]}
//   op_valid         opcode is captured on a clk edge where this is high
//   shape     [3:0]  registered shape code
//   color     [15:0] registered color field
//   opdata    [75:0] registered operand data, P0=[75:57] P1=[56:38] P2=[37:19] P3=[18:0]
//   out_valid        one-cycle strobe after each capture
//   shape_err        captured shape code is not line/triangle/circle (check build only)
// Modports: master = command source, slave = decoder.

interface opdecode_if;
    logic [95:0] opcode;
    logic        op_valid;
    logic [3:0]  shape;
    logic [15:0] color;
    logic [75:0] opdata;
    logic        out_valid;
    logic        shape_err;

    modport master (
        output opcode,
        output op_valid,
        input  shape,
        input  color,
        input  opdata,
        input  out_valid,
        input  shape_err
    );

    modport slave (
        input  opcode,
        input  op_valid,
        output shape,
        output color,
        output opdata,
        output out_valid,
        output shape_err
    );
endinterface

// File: rtl/opdecode.sv
// rtl/opdecode.sv - draw command field decode register stage
//
// Splits a 96-bit packed draw command into registered shape, color and
// operand fields one clock after op_valid. All outputs come straight from
// flops; opdata is passed through untouched for every shape, including
// points the shape does not use.
//
// Ports:
//   clk    rising-edge system clock
//   n_rst  synchronous active-low reset
//   bus    opdecode_if.slave (opcode/op_valid in; shape/color/opdata/
//          out_valid/shape_err out)
//
// Build option: OPDECODE_SHAPE_CHECK_EN - when defined, shape codes
// 0011..1111 raise shape_err (still passed through); when undefined,
// shape_err is held at 0.

module opdecode (
    input  logic       clk,
    input  logic       n_rst,
    opdecode_if.slave  bus
);

    localparam logic [3:0] SHAPE_LINE     = 4'b0000;
    localparam logic [3:0] SHAPE_TRIANGLE = 4'b0001;
    localparam logic [3:0] SHAPE_CIRCLE   = 4'b0010;

    logic [3:0]  r_shape;
    logic [15:0] r_color;
    logic [75:0] r_opdata;
    logic        r_out_valid;
    logic        r_shape_err;

    logic [3:0]  w_in_shape;
    logic        w_shape_bad;

    assign w_in_shape = bus.opcode[95:92];

`ifdef OPDECODE_SHAPE_CHECK_EN
    assign w_shape_bad = (w_in_shape != SHAPE_LINE) &&
                         (w_in_shape != SHAPE_TRIANGLE) &&
                         (w_in_shape != SHAPE_CIRCLE);
`else
    // Every code is accepted; the shape constants are only used by the check build.
    logic [11:0] w_unused_shapes;
    assign w_unused_shapes = {SHAPE_LINE, SHAPE_TRIANGLE, SHAPE_CIRCLE};
    assign w_shape_bad     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_shape     <= 4'h0;
            r_color     <= 16'h0000;
            r_opdata    <= 76'h0;
            r_out_valid <= 1'b0;
            r_shape_err <= 1'b0;
        end else begin
            // Strobe tracks op_valid directly, so back-to-back commands keep it high.
            r_out_valid <= bus.op_valid;
            if (bus.op_valid) begin
                r_shape     <= w_in_shape;
                r_color     <= bus.opcode[91:76];
                r_opdata    <= bus.opcode[75:0];
                r_shape_err <= w_shape_bad;
            end
        end
    end

    assign bus.shape     = r_shape;
    assign bus.color     = r_color;
    assign bus.opdata    = r_opdata;
    assign bus.out_valid = r_out_valid;
    assign bus.shape_err = r_shape_err;

endmodule

// File: tb/tb_opdecode.sv
// tb/tb_opdecode.sv - randomized self-checking bench for opdecode

module tb_opdecode;

`ifdef OPDECODE_SHAPE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;

    opdecode_if bus ();

    opdecode dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state: what the decoder should be presenting right now.
    logic [3:0]  e_shape;
    logic [15:0] e_color;
    logic [75:0] e_opdata;
    logic        e_valid;
    logic        e_err;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [95:0] make_op(input logic [3:0] sh, input logic [15:0] col,
                                            input logic [18:0] p0, input logic [18:0] p1,
                                            input logic [18:0] p2, input logic [18:0] p3);
        return {sh, col, p0, p1, p2, p3};
    endfunction

    function automatic logic [95:0] rand_op(input logic [3:0] sh);
        return make_op(sh, 16'($urandom), 19'($urandom), 19'($urandom),
                       19'($urandom), 19'($urandom));
    endfunction

    // Apply one clock of stimulus, advance the reference, then compare all outputs.
    task automatic cycle(input logic rst_n, input logic v, input logic [95:0] op,
                         input string tag);
        logic [95:0] tmp;
        n_rst        = rst_n;
        bus.op_valid = v;
        bus.opcode   = op;
        @(posedge clk);
        if (!rst_n) begin
            e_shape = '0; e_color = '0; e_opdata = '0; e_valid = 1'b0; e_err = 1'b0;
        end else if (v) begin
            tmp      = op;
            e_shape  = tmp[95:92];
            e_color  = tmp[91:76];
            e_opdata = tmp[75:0];
            e_valid  = 1'b1;
            e_err    = CHECK_EN && !(e_shape inside {4'd0, 4'd1, 4'd2});
        end else begin
            e_valid = 1'b0;
        end
        #1;
        check({tag, ".shape"},     96'(bus.shape),     96'(e_shape));
        check({tag, ".color"},     96'(bus.color),     96'(e_color));
        check({tag, ".opdata"},    96'(bus.opdata),    96'(e_opdata));
        check({tag, ".out_valid"}, 96'(bus.out_valid), 96'(e_valid));
        check({tag, ".shape_err"}, 96'(bus.shape_err), 96'(e_err));
    endtask

    logic [3:0] shapes [450];
    logic [95:0] all_ones;
    logic [95:0] op_a;

    initial begin
        n_rst        = 1'b0;
        bus.op_valid = 1'b0;
        bus.opcode   = '0;
        all_ones     = '1;
        e_shape = '0; e_color = '0; e_opdata = '0; e_valid = 1'b0; e_err = 1'b0;

        // Reset with op_valid high and an all-ones command: must be discarded.
        cycle(1'b0, 1'b1, all_ones, "reset0");
        cycle(1'b0, 1'b1, all_ones, "reset1");

        // Line command with alternating points.
        op_a = make_op(4'b0000, 16'hFFFF, 19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF);
        cycle(1'b1, 1'b1, op_a, "line");
        cycle(1'b1, 1'b0, op_a, "line_drop");
        check("line_opdata_p3", 96'(bus.opdata[18:0]), 96'(19'h7FFFF));

        // Triangle then circle back-to-back.
        cycle(1'b1, 1'b1, make_op(4'b0001, 16'h0000, 19'h7FFFF, 19'h0, 19'h7FFFF, 19'h0), "tri");
        cycle(1'b1, 1'b1, make_op(4'b0010, 16'hFFFF, 19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF), "circ");

        // Hold: opcode wiggles with op_valid low.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, {$urandom, $urandom, $urandom}, "hold");

        // Reset mid-stream with a command pending, then a fresh capture.
        cycle(1'b1, 1'b1, rand_op(4'b0001), "pre_rst");
        cycle(1'b0, 1'b1, all_ones, "mid_rst");
        cycle(1'b1, 1'b1, rand_op(4'b0010), "post_rst");

        // Shape check: illegal code then a legal one.
        cycle(1'b1, 1'b1, rand_op(4'b0101), "bad_shape");
        check("bad_shape.err_direct", 96'(bus.shape_err), 96'(CHECK_EN));
        cycle(1'b1, 1'b1, rand_op(4'b0000), "good_shape");

        // Random: 150 of each legal shape, shuffled, with random idle gaps.
        for (int i = 0; i < 450; i++) shapes[i] = 4'(i / 150);
        for (int i = 449; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = $urandom_range(0, i);
            t = shapes[i]; shapes[i] = shapes[j]; shapes[j] = t;
        end
        for (int i = 0; i < 450; i++) begin
            cycle(1'b1, 1'b1, rand_op(shapes[i]), "rand");
            if ($urandom_range(0, 3) == 0)
                cycle(1'b1, 1'b0, {$urandom, $urandom, $urandom}, "rand_idle");
        end

        // Random over all 16 shape codes to exercise shape_err both ways.
        for (int i = 0; i < 64; i++)
            cycle(1'b1, 1'b1, rand_op(4'($urandom)), "rand_all");
        cycle(1'b1, 1'b0, '0, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opdecode.md
OPDECODE -- requirements
Module: opdecode

Interface
REQ-001 Parameters: none; all field widths fixed as listed.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 n_rst  input  1  reset, synchronous, active-low; sampled on rising clk edge only.
REQ-004 opcode  input  96  packed draw command: [95:92] shape, [91:76] color, [75:0] operand data.
REQ-005 op_valid  input  1  opcode is captured on a clk edge where op_valid=1.
REQ-006 shape  output  4  registered shape code (0000 line, 0001 triangle, 0010 circle).
REQ-007 color  output  16  registered color field.
REQ-008 opdata  output  76  registered operand data: four 19-bit points, P0=[75:57], P1=[56:38], P2=[37:19], P3=[18:0].
REQ-009 out_valid  output  1  high for exactly one cycle after each capture.
REQ-010 shape_err  output  1  captured shape code is not 0000/0001/0010 (behaviour per Configuration).

Function
REQ-011 On a rising clk with n_rst=1 and op_valid=1: shape<=opcode[95:92], color<=opcode[91:76], opdata<=opcode[75:0], all bit-exact, no reordering.
REQ-012 Latency: outputs reflect the captured opcode on the edge following op_valid; out_valid rises on that same edge.
REQ-013 With op_valid=0: shape, color, opdata, shape_err hold their last values; out_valid<=0.
REQ-014 op_valid=1 on consecutive cycles: each cycle's opcode captured; out_valid stays 1; no command dropped or merged.
REQ-015 opdata passed through for every shape, including unused points (line uses P0-P1, triangle P0-P2, circle P0 centre + P1 radius); unused points not zeroed.
REQ-016 opcode changes while op_valid=0 have no effect on outputs.
REQ-017 All outputs driven from flops only; no combinational path from opcode to any output.

Reset
REQ-018 n_rst=0 on a rising clk: shape=0000, color=0x0000, opdata=0, out_valid=0, shape_err=0, regardless of op_valid.
REQ-019 Reset takes priority over a simultaneous op_valid=1; that opcode is discarded.
REQ-020 Reset mid-stream: first capture after n_rst returns high behaves identically to a capture after power-up.

Configuration
REQ-021 Macro OPDECODE_SHAPE_CHECK_EN defined: captured shape codes 0011-1111 set shape_err=1 and are still passed through on shape/color/opdata; out_valid asserts normally; a valid code clears shape_err.
REQ-022 Macro undefined: shape_err tied 0; all 16 shape codes treated as valid; no other behaviour changes.

Verification
REQ-023 Reset: n_rst=0 for 2 cycles with op_valid=1, opcode all ones -> all outputs 0, out_valid=0.
REQ-024 Line: opcode={0000,16'hFFFF,19'h0,19'h7FFFF,19'h0,19'h7FFFF}, op_valid one cycle -> next edge shape=0000, color=FFFF, opdata[75:19]=input[75:19], opdata[18:0]=7FFFF, out_valid=1 for one cycle.
REQ-025 Triangle then circle back-to-back: {0001,16'h0000,19'h7FFFF,19'h0,19'h7FFFF,19'h0} then {0010,16'hFFFF,19'h0,19'h7FFFF,19'h0,19'h7FFFF} -> matching outputs on consecutive cycles, out_valid high both cycles.
REQ-026 Hold: after a capture, change opcode with op_valid=0 for 5 cycles -> outputs unchanged, out_valid=0.
REQ-027 Random: 450 commands (150 each shape 0000/0001/0010), random color and 19-bit points -> every shape, color, opdata matches captured opcode one cycle later; shape_err=0 throughout.
REQ-028 With OPDECODE_SHAPE_CHECK_EN: shape 0101 -> shape=0101, shape_err=1; next shape 0000 -> shape_err=0; without macro shape_err stays 0.
